// File: rtl/dbus_sram_responder.sv
// Word-organised SRAM target on the CPU data bus. Each request is answered
// after a programmable number of wait states.
module dbus_sram_responder #(
   parameter int ADDR_WIDTH  = 10,
   parameter int WAIT_CYCLES = 2
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] dbus_addr,
   input  logic        dbus_read,
   input  logic        dbus_write,
   input  logic [31:0] dbus_wdata,
   input  logic [3:0]  dbus_byteenable,
   input  logic        exr_valid_mem,
   input  logic        pipe_hold,
   output logic [31:0] dbus_data,
   output logic        dbus_stall,
   output logic        bus_error,
   output logic [31:0] rd_count,
   output logic [31:0] wr_count
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;

   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} state_t;

   logic [31:0] mem [DEPTH];

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [31:2] addr_q, addr_d;
   logic        wr_op_q, wr_op_d;
   logic [31:0] wdata_q, wdata_d;
   logic [3:0]  be_q, be_d;
   logic [31:0] data_q, data_d;
   logic        berr_q, berr_d;
   logic [31:0] rd_cnt_q, rd_cnt_d;
   logic [31:0] wr_cnt_q, wr_cnt_d;

   logic                  req;
   logic                  access;
   logic                  mem_we;
   logic                  oor_q;
   logic [ADDR_WIDTH-1:0] idx_q;
   logic                  unused_addr_bits;

   assign req              = (dbus_read | dbus_write) & ~exr_valid_mem;
   assign idx_q            = addr_q[ADDR_WIDTH+1:2];
   assign oor_q            = |addr_q[31:ADDR_WIDTH+2];
   assign unused_addr_bits = ^dbus_addr[1:0];

   // The access commits on the edge that ends the last wait cycle.
   assign access = (state_q == ST_WAIT) && req && (cnt_q == 4'd0);
   assign mem_we = access && wr_op_q && !oor_q;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      addr_d   = addr_q;
      wr_op_d  = wr_op_q;
      wdata_d  = wdata_q;
      be_d     = be_q;
      data_d   = data_q;
      berr_d   = berr_q;
      rd_cnt_d = rd_cnt_q;
      wr_cnt_d = wr_cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (req) begin
               addr_d  = dbus_addr[31:2];
               wr_op_d = dbus_write;
               wdata_d = dbus_wdata;
               be_d    = dbus_byteenable;
               cnt_d   = 4'(WAIT_CYCLES - 1);
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (!req) begin
               state_d = ST_IDLE;
            end else if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               state_d = ST_DONE;
               berr_d  = oor_q;
               if (wr_op_q) begin
                  wr_cnt_d = wr_cnt_q + 32'd1;
               end else begin
                  rd_cnt_d = rd_cnt_q + 32'd1;
                  data_d   = oor_q ? 32'd0 : mem[idx_q];
               end
            end
         end
         ST_DONE: begin
            if (!pipe_hold) begin
               state_d = ST_IDLE;
               berr_d  = 1'b0;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      case (state_q)
         ST_IDLE: dbus_stall = req;
         ST_WAIT: dbus_stall = 1'b1;
         default: dbus_stall = 1'b0;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         cnt_q    <= 4'd0;
         data_q   <= 32'd0;
         berr_q   <= 1'b0;
         rd_cnt_q <= 32'd0;
         wr_cnt_q <= 32'd0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         data_q   <= data_d;
         berr_q   <= berr_d;
         rd_cnt_q <= rd_cnt_d;
         wr_cnt_q <= wr_cnt_d;
      end
   end

   // Request capture registers carry no reset; they are only consumed in WAIT.
   always_ff @(posedge clock) begin
      addr_q  <= addr_d;
      wr_op_q <= wr_op_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
   end

   always_ff @(posedge clock) begin
      if (mem_we) begin
         for (int i = 0; i < 4; i++) begin
            if (be_q[i]) mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
         end
      end
   end

   assign dbus_data = data_q;
   assign bus_error = berr_q;
   assign rd_count  = rd_cnt_q;
   assign wr_count  = wr_cnt_q;

endmodule

// File: tb/tb_dbus_sram_responder.sv
// Directed bench for dbus_sram_responder with a reference memory model and a
// queue of expected read data popped when each transaction completes.
module tb_dbus_sram_responder;

   localparam int AW = 10;
   localparam int WC = 2;

   logic        clock = 1'b0;
   logic        reset;
   logic [31:0] dbus_addr;
   logic        dbus_read;
   logic        dbus_write;
   logic [31:0] dbus_wdata;
   logic [3:0]  dbus_byteenable;
   logic        exr_valid_mem;
   logic        pipe_hold;
   logic [31:0] dbus_data;
   logic        dbus_stall;
   logic        bus_error;
   logic [31:0] rd_count;
   logic [31:0] wr_count;

   int total = 0;
   int bad   = 0;
   int exp_rd = 0;
   int exp_wr = 0;
   logic [31:0] exp_q [$];
   logic [31:0] model [int];

   dbus_sram_responder #(.ADDR_WIDTH(AW), .WAIT_CYCLES(WC)) dut (
      .clock(clock), .reset(reset), .dbus_addr(dbus_addr), .dbus_read(dbus_read),
      .dbus_write(dbus_write), .dbus_wdata(dbus_wdata), .dbus_byteenable(dbus_byteenable),
      .exr_valid_mem(exr_valid_mem), .pipe_hold(pipe_hold), .dbus_data(dbus_data),
      .dbus_stall(dbus_stall), .bus_error(bus_error), .rd_count(rd_count), .wr_count(wr_count)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic bit is_oor(input logic [31:0] addr);
      return addr[31:AW+2] != 0;
   endfunction

   function automatic int word_idx(input logic [31:0] addr);
      return int'(addr[AW+1:2]);
   endfunction

   task automatic model_write(input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] be);
      logic [31:0] w;
      if (is_oor(addr)) return;
      w = model.exists(word_idx(addr)) ? model[word_idx(addr)] : 32'd0;
      for (int i = 0; i < 4; i++) if (be[i]) w[8*i +: 8] = wd[8*i +: 8];
      model[word_idx(addr)] = w;
   endtask

   function automatic logic [31:0] model_read(input logic [31:0] addr);
      if (is_oor(addr)) return 32'd0;
      return model[word_idx(addr)];
   endfunction

   // One complete transaction; hold_n > 1 keeps pipe_hold high for hold_n DONE cycles.
   task automatic xact(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [3:0] be, input int hold_n, input string tag);
      int          stalls;
      bit          done;
      logic        exp_berr;
      logic [31:0] exp_data;
      logic [31:0] cap;
      exp_berr = is_oor(addr);
      if (!wr) exp_q.push_back(model_read(addr));
      @(posedge clock); #1;
      dbus_addr = addr; dbus_write = wr; dbus_read = !wr;
      dbus_wdata = wd; dbus_byteenable = be; pipe_hold = (hold_n > 1);
      stalls = 0;
      done = 1'b0;
      for (int i = 0; i < 50 && !done; i++) begin
         @(negedge clock);
         if (dbus_stall) stalls++;
         else done = 1'b1;
      end
      check({tag, "_done"}, 32'(done), 32'd1);
      check({tag, "_stall_cycles"}, 32'(stalls), 32'(WC + 1));
      if (wr) begin
         model_write(addr, wd, be);
         exp_wr++;
      end else begin
         exp_rd++;
         exp_data = exp_q.pop_front();
         check({tag, "_data"}, dbus_data, exp_data);
      end
      check({tag, "_bus_error"}, 32'(bus_error), 32'(exp_berr));
      check({tag, "_rd_count"}, rd_count, 32'(exp_rd));
      check({tag, "_wr_count"}, wr_count, 32'(exp_wr));
      cap = dbus_data;
      for (int i = 1; i < hold_n; i++) begin
         @(posedge clock); #1;
         if (i == hold_n - 1) pipe_hold = 1'b0;
         @(negedge clock);
         check({tag, "_hold_stall"}, 32'(dbus_stall), 32'd0);
         check({tag, "_hold_data"}, dbus_data, cap);
         check({tag, "_hold_rd_count"}, rd_count, 32'(exp_rd));
      end
      @(posedge clock); #1;
      dbus_read = 1'b0; dbus_write = 1'b0; pipe_hold = 1'b0;
   endtask

   task automatic abort_xact(input bit wr, input logic [31:0] addr, input string tag);
      @(posedge clock); #1;
      dbus_addr = addr; dbus_write = wr; dbus_read = !wr;
      dbus_wdata = 32'h0000_0000; dbus_byteenable = 4'hF;
      @(negedge clock);
      check({tag, "_idle_stall"}, 32'(dbus_stall), 32'd1);
      @(posedge clock); #1;
      exr_valid_mem = 1'b1;
      @(negedge clock);
      check({tag, "_wait_stall"}, 32'(dbus_stall), 32'd1);
      @(posedge clock); #1;
      dbus_read = 1'b0; dbus_write = 1'b0; exr_valid_mem = 1'b0;
      @(negedge clock);
      check({tag, "_after_stall"}, 32'(dbus_stall), 32'd0);
      check({tag, "_rd_count"}, rd_count, 32'(exp_rd));
      check({tag, "_wr_count"}, wr_count, 32'(exp_wr));
   endtask

   task automatic idle_check(input string tag);
      @(negedge clock);
      check({tag, "_idle_bus_error"}, 32'(bus_error), 32'd0);
      check({tag, "_idle_stall"}, 32'(dbus_stall), 32'd0);
   endtask

   initial begin
      reset = 1'b1;
      dbus_addr = 32'd0; dbus_read = 1'b0; dbus_write = 1'b0; dbus_wdata = 32'd0;
      dbus_byteenable = 4'h0; exr_valid_mem = 1'b0; pipe_hold = 1'b0;
      repeat (2) @(negedge clock);
      check("rst_stall", 32'(dbus_stall), 32'd0);
      check("rst_data", dbus_data, 32'd0);
      check("rst_bus_error", 32'(bus_error), 32'd0);
      check("rst_rd_count", rd_count, 32'd0);
      check("rst_wr_count", wr_count, 32'd0);
      @(posedge clock); #1;
      reset = 1'b0;

      // Basic write then read-back.
      xact(1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 4'hF, 1, "t1_wr");
      xact(1'b0, 32'h0000_0040, 32'h0, 4'hF, 1, "t1_rd");

      // Partial byte lanes, then an all-disabled write.
      xact(1'b1, 32'h0000_0080, 32'hAABB_CCDD, 4'hF, 1, "t2_wr_full");
      xact(1'b1, 32'h0000_0080, 32'h1122_3344, 4'b0101, 1, "t2_wr_part");
      xact(1'b0, 32'h0000_0080, 32'h0, 4'hF, 1, "t2_rd");
      check("t2_merged_const", dbus_data, 32'hAA22_CC44);
      xact(1'b1, 32'h0000_0080, 32'hFFFF_FFFF, 4'b0000, 1, "t2_wr_be0");
      xact(1'b0, 32'h0000_0080, 32'h0, 4'hF, 1, "t2_rd_be0");

      // Exception in the first wait cycle voids the request.
      abort_xact(1'b1, 32'h0000_0040, "t3_abort_wr");
      abort_xact(1'b0, 32'h0000_0040, "t3_abort_rd");
      xact(1'b0, 32'h0000_0040, 32'h0, 4'hF, 1, "t3_rd_after");

      // Out-of-range accesses alias nothing and flag bus_error for one DONE cycle.
      xact(1'b1, 32'h0000_0000, 32'hCAFE_F00D, 4'hF, 1, "t4_wr_idx0");
      xact(1'b1, 32'h0010_0000, 32'h1234_5678, 4'hF, 1, "t4_wr_oor");
      idle_check("t4_wr_oor");
      xact(1'b0, 32'h0010_0000, 32'h0, 4'hF, 1, "t4_rd_oor");
      idle_check("t4_rd_oor");
      xact(1'b0, 32'h0000_0000, 32'h0, 4'hF, 1, "t4_rd_idx0");

      // DONE held by pipe_hold for three cycles.
      xact(1'b0, 32'h0000_0080, 32'h0, 4'hF, 3, "t5_hold");
      idle_check("t5_hold");

      // Reset in the middle of a write drops it; memory survives.
      xact(1'b1, 32'h0000_0100, 32'h5555_AAAA, 4'hF, 1, "t6_wr_old");
      @(posedge clock); #1;
      dbus_addr = 32'h0000_0100; dbus_write = 1'b1; dbus_wdata = 32'h0BAD_BEEF;
      dbus_byteenable = 4'hF;
      @(posedge clock); #1;
      reset = 1'b1;
      dbus_write = 1'b0;
      #1;
      check("t6_rst_stall", 32'(dbus_stall), 32'd0);
      check("t6_rst_rd_count", rd_count, 32'd0);
      check("t6_rst_wr_count", wr_count, 32'd0);
      exp_rd = 0;
      exp_wr = 0;
      @(posedge clock); #1;
      reset = 1'b0;
      xact(1'b0, 32'h0000_0100, 32'h0, 4'hF, 1, "t6_rd_old");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
